ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one port of the block RAM (write-first, registered read) between two requesters, e.g. a host-side loader and a pattern engine.
- Round-robin arbitration with valid/ready handshakes and an optional lock for back-to-back bursts.
- Drives the RAM port from registers and routes read data back to the requester that issued the read.
- Sits between the requesters and one port of the true dual-port RAM instance in the FPGA top level.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 10, RAM address width.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester grant; a request is accepted when valid&ready.
- req_write  input  2  per-requester: 1 = write, 0 = read.
- req_lock  input  2  per-requester: keep the grant on the next cycle.
- req_addr0, req_addr1  input  ADDR_WIDTH  request address.
- req_wdata0, req_wdata1  input  DATA_WIDTH  write data.
- rsp_valid  output  2  one-cycle pulse: read data for requester i is valid.
- rsp_data  output  DATA_WIDTH  shared read data, qualified by rsp_valid.
- ram_enable  output  1  RAM port enable.
- ram_write  output  1  RAM port write strobe.
- ram_addr  output  ADDR_WIDTH  RAM port address.
- ram_idata  output  DATA_WIDTH  RAM write data.
- ram_odata  input  DATA_WIDTH  RAM read data; valid 1 cycle after ram_enable (2 cycles with RAM_OREG_EN).

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, ram_enable=0, ram_write=0, ram_addr=0, ram_idata=0. last_grant=1, so requester 0 wins first after reset. Lock is cleared and the tag pipeline is emptied.
- Grant is combinational from req_valid, last_grant and the lock state. req_ready is one-hot or zero and never asserts for a requester whose req_valid is low.
- Only one grant per cycle. No backpressure: a request can be accepted every cycle.
- Arbitration, in order:
  - If the lock owner has req_valid high, the lock owner wins.
  - Otherwise, if only one requester is valid, it wins.
  - Otherwise (both valid), the requester that is not last_grant wins.
  - last_grant updates on every accept.
- Lock:
  - Set to owner i when requester i is accepted with req_lock[i]=1.
  - Cleared when the owner is accepted with req_lock=0, or when the owner drops req_valid for one cycle. The other requester may win that same cycle.
- RAM drive: on the cycle after an accept, ram_enable=1 and ram_write/ram_addr/ram_idata carry the accepted request. With no accept, ram_enable=0, ram_write=0, and addr/data hold their previous values.
- Read return:
  - A tag pipeline carries {is_read, requester id} and matches the RAM latency.
  - rsp_valid[id] pulses and rsp_data is registered from ram_odata.
  - Accept-to-rsp_valid latency is 3 cycles (4 with RAM_OREG_EN).
  - Writes produce no response.
- rsp_data holds its last value while rsp_valid=0.
- Back-to-back reads from alternating requesters return in issue order, one per cycle.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid is issued for them. The RAM write already on the port completes; the port output registers are cleared.

Optional Feature:
- RAM_OREG_EN defined: the RAM is built with its output register. The tag pipeline gains one stage and the read latency is 4 cycles from accept.
- Not defined: the read latency is 3 cycles.
- Arbitration and handshakes are identical in both cases.

Decomposition:
- Shared package holds:
  - requester id width (1) and count (2);
  - the tag struct {is_read, id};
  - the latency constant, derived from RAM_OREG_EN.
- Natural sub-module rr_arbiter2: combinational grant from valid, last_grant and lock, plus the last_grant and lock registers.
- The top block holds the RAM-port registers and the tag pipeline.

Test Plan:
- Reset released with req_valid=00 -> all outputs 0 and ram_enable low for 10 cycles.
- Requester 0 writes addr 0x005 data 0xA5, then 3 cycles later reads 0x005 -> ram_write pulses once; rsp_valid=01 with rsp_data=0xA5 exactly 3 cycles after the read accept (4 with RAM_OREG_EN).
- Both requesters hold valid for 6 cycles, reading 0x010 and 0x020 -> grants alternate 0,1,0,1,0,1; rsp_valid alternates 01,10 with matching data, in order.
- Requester 1 asserts lock for 3 accepts while requester 0 is valid throughout -> requester 1 gets 4 consecutive grants (3 locked plus the release), then requester 0 is granted.
- Lock owner drops valid for one cycle while the other requester is valid -> the other requester is granted that cycle and the lock is cleared.
- reset asserted one cycle after two read accepts -> rsp_valid never pulses for those reads, and all outputs are 0 asynchronously.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared types and constants for the two-requester RAM port arbiter.
//   Optional build macro: RAM_OREG_EN (RAM built with its output register,
//   one extra cycle of read latency).
package ram_port_arbiter_pkg;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned ID_WIDTH = 1;

    // Travels alongside each RAM access so read data can be routed home.
    typedef struct packed {
        logic                is_read;
        logic [ID_WIDTH-1:0] id;
    } tag_t;

`ifdef RAM_OREG_EN
    localparam int unsigned RAM_LATENCY = 2;
`else
    localparam int unsigned RAM_LATENCY = 1;
`endif

    // One stage for the port register, then one per RAM read cycle.
    localparam int unsigned TAG_DEPTH  = RAM_LATENCY + 1;
    // Accept to rsp_valid, including the response register.
    localparam int unsigned RD_LATENCY = TAG_DEPTH + 1;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_WIDTH-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Bundles the requester handshakes, the read-return bus and the RAM port.
//   master : requester / RAM side (drives requests and ram_odata)
//   slave  : arbiter side (drives grants, responses and the RAM port)
interface ram_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_write;
    logic [1:0]            req_lock;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_wdata0;
    logic [DATA_WIDTH-1:0] req_wdata1;
    logic [1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  ram_enable;
    logic                  ram_write;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_idata;
    logic [DATA_WIDTH-1:0] ram_odata;

    modport master (
        output req_valid, req_write, req_lock, req_addr0, req_addr1,
               req_wdata0, req_wdata1, ram_odata,
        input  req_ready, rsp_valid, rsp_data, ram_enable, ram_write,
               ram_addr, ram_idata
    );

    modport slave (
        input  req_valid, req_write, req_lock, req_addr0, req_addr1,
               req_wdata0, req_wdata1, ram_odata,
        output req_ready, rsp_valid, rsp_data, ram_enable, ram_write,
               ram_addr, ram_idata
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter with a per-owner lock.
//   clock, reset : clock, asynchronous active-high reset
//   i_valid      : request valid per requester
//   i_lock       : keep the grant after this accept
//   o_grant      : one-hot grant (zero when idle or in reset)
//   o_grant_id   : index of the granted requester, meaningful when o_grant != 0
module rr_arbiter2
    import ram_port_arbiter_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  i_valid,
    input  logic [NUM_REQ-1:0]  i_lock,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grant_id
);

    logic [ID_WIDTH-1:0] r_last_grant;
    logic                r_lock_active;
    logic [ID_WIDTH-1:0] r_lock_owner;

    logic                w_any;
    logic [ID_WIDTH-1:0] w_gnt_id;
    logic [ID_WIDTH-1:0] w_last_grant_next;
    logic                w_lock_active_next;
    logic [ID_WIDTH-1:0] w_lock_owner_next;

    always_comb begin
        w_any    = (|i_valid) & ~reset;
        w_gnt_id = '0;
        if (r_lock_active && i_valid[r_lock_owner]) begin
            w_gnt_id = r_lock_owner;
        end else if (i_valid == 2'b01) begin
            w_gnt_id = 1'b0;
        end else if (i_valid == 2'b10) begin
            w_gnt_id = 1'b1;
        end else begin
            w_gnt_id = ~r_last_grant;
        end
        o_grant    = w_any ? id_onehot(w_gnt_id) : '0;
        o_grant_id = w_gnt_id;
    end

    always_comb begin
        w_last_grant_next  = r_last_grant;
        w_lock_active_next = r_lock_active;
        w_lock_owner_next  = r_lock_owner;
        // Owner walking away releases the lock; the other side may already win this cycle.
        if (r_lock_active && !i_valid[r_lock_owner]) begin
            w_lock_active_next = 1'b0;
        end
        if (w_any) begin
            w_last_grant_next = w_gnt_id;
            if (i_lock[w_gnt_id]) begin
                w_lock_active_next = 1'b1;
                w_lock_owner_next  = w_gnt_id;
            end else if (r_lock_active && (w_gnt_id == r_lock_owner)) begin
                w_lock_active_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_lock_active <= 1'b0;
            r_lock_owner  <= '0;
        end else begin
            r_last_grant  <= w_last_grant_next;
            r_lock_active <= w_lock_active_next;
            r_lock_owner  <= w_lock_owner_next;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one block-RAM port between two requesters. Requests are granted
//   round-robin (with optional lock), the RAM port is driven from registers
//   the cycle after an accept, and read data is routed back to its requester.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : ram_port_arbiter_if.slave (requests, responses, RAM port)
//   Build macro RAM_OREG_EN: RAM has an output register; read latency 4 instead of 3.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic               clock,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_WIDTH-1:0]   w_gnt_id;
    logic                  w_accept;
    logic                  w_write;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    logic                  r_ram_enable;
    logic                  r_ram_write;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_idata;
    tag_t                  r_tag [TAG_DEPTH];
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    rr_arbiter2 u_arb (
        .clock      (clock),
        .reset      (reset),
        .i_valid    (bus.req_valid),
        .i_lock     (bus.req_lock),
        .o_grant    (w_grant),
        .o_grant_id (w_gnt_id)
    );

    assign w_accept = |w_grant;
    assign w_write  = bus.req_write[w_gnt_id];
    assign w_addr   = w_gnt_id[0] ? bus.req_addr1  : bus.req_addr0;
    assign w_wdata  = w_gnt_id[0] ? bus.req_wdata1 : bus.req_wdata0;

    // RAM port registers: address/data hold between accesses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ram_enable <= 1'b0;
            r_ram_write  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_idata  <= '0;
        end else begin
            r_ram_enable <= w_accept;
            r_ram_write  <= w_accept & w_write;
            if (w_accept) begin
                r_ram_addr  <= w_addr;
                r_ram_idata <= w_wdata;
            end
        end
    end

    // Tag pipeline: stage 0 lines up with the port register, the last stage with ram_odata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0].is_read <= w_accept & ~w_write;
            r_tag[0].id      <= w_gnt_id;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_tag[TAG_DEPTH-1].is_read ? id_onehot(r_tag[TAG_DEPTH-1].id) : '0;
            if (r_tag[TAG_DEPTH-1].is_read) begin
                r_rsp_data <= bus.ram_odata;
            end
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.ram_enable = r_ram_enable;
    assign bus.ram_write  = r_ram_write;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_idata  = r_ram_idata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Scoreboard bench for ram_port_arbiter with a behavioural write-first RAM.
//   Honours RAM_OREG_EN for the RAM model and the expected read latency.
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 10;
`ifdef RAM_OREG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int          id;
        logic [7:0]  data;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [7:0]  data;
        int          cyc;
    } ram_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    rsp_exp_t   rsp_q[$];
    ram_exp_t   ram_q[$];
    logic [7:0] last_rsp = '0;
    logic [9:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural RAM port: write-first, registered read.
    logic [7:0] mem [1024];
    logic [7:0] ram_r1 = '0;
    logic [7:0] ram_r2 = '0;
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    always @(posedge clock) begin
        if (bus.ram_enable) begin
            if (bus.ram_write) begin
                mem[bus.ram_addr] <= bus.ram_idata;
                ram_r1 <= bus.ram_idata;
            end else begin
                ram_r1 <= mem[bus.ram_addr];
            end
        end
        ram_r2 <= ram_r1;
    end
`ifdef RAM_OREG_EN
    assign bus.ram_odata = ram_r2;
`else
    assign bus.ram_odata = ram_r1;
`endif

    // Response monitor.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            checks++;
            if (bus.rsp_valid != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected cyc=%0d rsp_valid=%b data=%h required no response",
                             cyc, bus.rsp_valid, bus.rsp_data);
                end else begin
                    rsp_exp_t e;
                    logic [1:0] ev;
                    e  = rsp_q.pop_front();
                    ev = (e.id == 0) ? 2'b01 : 2'b10;
                    last_rsp = e.data;
                    if (bus.rsp_valid !== ev || bus.rsp_data !== e.data || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL rsp cyc=%0d rsp_valid=%b data=%h required cyc=%0d rsp_valid=%b data=%h",
                                 cyc, bus.rsp_valid, bus.rsp_data, e.cyc, ev, e.data);
                    end
                end
            end else if (bus.rsp_data !== last_rsp) begin
                failures++;
                $display("FAIL rsp_hold cyc=%0d rsp_data=%h required %h", cyc, bus.rsp_data, last_rsp);
            end
        end
    end

    // RAM port monitor.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            checks++;
            if (ram_q.size() != 0 && ram_q[0].cyc <= cyc) begin
                ram_exp_t e;
                e = ram_q.pop_front();
                last_addr = e.addr;
                last_data = e.data;
                if (bus.ram_enable !== 1'b1 || bus.ram_write !== e.we || bus.ram_addr !== e.addr ||
                    bus.ram_idata !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL ram_op cyc=%0d en=%b we=%b addr=%h data=%h required cyc=%0d en=1 we=%b addr=%h data=%h",
                             cyc, bus.ram_enable, bus.ram_write, bus.ram_addr, bus.ram_idata,
                             e.cyc, e.we, e.addr, e.data);
                end
            end else if (bus.ram_enable !== 1'b0 || bus.ram_write !== 1'b0 ||
                         bus.ram_addr !== last_addr || bus.ram_idata !== last_data) begin
                failures++;
                $display("FAIL ram_idle cyc=%0d en=%b we=%b addr=%h data=%h required en=0 we=0 addr=%h data=%h",
                         cyc, bus.ram_enable, bus.ram_write, bus.ram_addr, bus.ram_idata,
                         last_addr, last_data);
            end
        end
    end

    function automatic logic [31:0] all_outputs();
        return {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.ram_enable, bus.ram_write,
                bus.ram_addr, bus.ram_idata};
    endfunction

    task automatic check_zero(input string name);
        checks++;
        if (all_outputs() !== 32'h0) begin
            failures++;
            $display("FAIL %s outputs=%h required 00000000", name, all_outputs());
        end
    endtask

    // One clock: check the grant at mid-cycle, queue the expected RAM op and response.
    task automatic step(input logic [1:0] exp_gnt, input logic [7:0] d0, input logic [7:0] d1,
                        input string name);
        @(negedge clock);
        checks++;
        if (bus.req_ready !== exp_gnt) begin
            failures++;
            $display("FAIL %s cyc=%0d req_ready=%b required %b", name, cyc, bus.req_ready, exp_gnt);
        end
        for (int i = 0; i < 2; i++) begin
            if (exp_gnt[i]) begin
                ram_exp_t r;
                r.we   = bus.req_write[i];
                r.addr = (i == 0) ? bus.req_addr0 : bus.req_addr1;
                r.data = (i == 0) ? bus.req_wdata0 : bus.req_wdata1;
                r.cyc  = cyc + 1;
                ram_q.push_back(r);
                if (!bus.req_write[i]) begin
                    rsp_exp_t e;
                    e.id   = i;
                    e.data = (i == 0) ? d0 : d1;
                    e.cyc  = cyc + LAT;
                    rsp_q.push_back(e);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                         input logic [9:0] a0, input logic [7:0] wd0,
                         input logic [9:0] a1, input logic [7:0] wd1);
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_lock   = l;
        bus.req_addr0  = a0;
        bus.req_wdata0 = wd0;
        bus.req_addr1  = a1;
        bus.req_wdata1 = wd1;
    endtask

    task automatic idle(input int n);
        drive(2'b00, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00);
        for (int i = 0; i < n; i++) step(2'b00, 8'h00, 8'h00, "idle");
    endtask

    initial begin
        drive(2'b00, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset_state");
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_zero("post_reset_idle");
            @(posedge clock);
            #1;
        end

        // Write 0xA5 to 0x005, then read it back three cycles later.
        drive(2'b01, 2'b01, 2'b00, 10'h005, 8'hA5, 10'h000, 8'h00);
        step(2'b01, 8'h00, 8'h00, "wr_grant");
        idle(2);
        drive(2'b01, 2'b00, 2'b00, 10'h005, 8'h00, 10'h000, 8'h00);
        step(2'b01, 8'hA5, 8'h00, "rd_grant");
        idle(6);

        // Preload 0x010 / 0x020 from each side.
        drive(2'b01, 2'b01, 2'b00, 10'h010, 8'h11, 10'h000, 8'h00);
        step(2'b01, 8'h00, 8'h00, "preload0");
        drive(2'b10, 2'b10, 2'b00, 10'h000, 8'h00, 10'h020, 8'h22);
        step(2'b10, 8'h00, 8'h00, "preload1");
        idle(2);

        // Both reading continuously: strict alternation starting with requester 0.
        drive(2'b11, 2'b00, 2'b00, 10'h010, 8'h00, 10'h020, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step((i % 2 == 0) ? 2'b01 : 2'b10, 8'h11, 8'h22, "alternate");
        end
        idle(6);

        // Requester 1 locks for 3 accepts plus the releasing accept.
        drive(2'b01, 2'b00, 2'b00, 10'h010, 8'h00, 10'h020, 8'h00);
        step(2'b01, 8'h11, 8'h22, "lock_setup");
        drive(2'b11, 2'b00, 2'b10, 10'h010, 8'h00, 10'h020, 8'h00);
        for (int i = 0; i < 3; i++) step(2'b10, 8'h11, 8'h22, "lock_held");
        drive(2'b11, 2'b00, 2'b00, 10'h010, 8'h00, 10'h020, 8'h00);
        step(2'b10, 8'h11, 8'h22, "lock_release");
        drive(2'b01, 2'b00, 2'b00, 10'h010, 8'h00, 10'h020, 8'h00);
        step(2'b01, 8'h11, 8'h22, "after_lock");
        idle(6);

        // Lock owner drops valid for one cycle.
        drive(2'b10, 2'b00, 2'b10, 10'h010, 8'h00, 10'h020, 8'h00);
        step(2'b10, 8'h11, 8'h22, "drop_lock_set");
        drive(2'b11, 2'b00, 2'b10, 10'h010, 8'h00, 10'h020, 8'h00);
        step(2'b10, 8'h11, 8'h22, "drop_lock_held");
        drive(2'b01, 2'b00, 2'b00, 10'h010, 8'h00, 10'h020, 8'h00);
        step(2'b01, 8'h11, 8'h22, "drop_other_wins");
        drive(2'b11, 2'b00, 2'b00, 10'h010, 8'h00, 10'h020, 8'h00);
        step(2'b10, 8'h11, 8'h22, "drop_rr1");
        step(2'b01, 8'h11, 8'h22, "drop_rr0");
        idle(6);

        // Two reads in flight, then reset: responses must never appear.
        drive(2'b11, 2'b00, 2'b00, 10'h010, 8'h00, 10'h020, 8'h00);
        step(2'b10, 8'h11, 8'h22, "rst_rd1");
        step(2'b01, 8'h11, 8'h22, "rst_rd0");
        reset = 1'b1;
        rsp_q.delete();
        ram_q.delete();
        last_rsp  = '0;
        last_addr = '0;
        last_data = '0;
        #1;
        check_zero("async_reset");
        @(posedge clock);
        #1;
        check_zero("reset_held");
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(8);

        checks++;
        if (rsp_q.size() != 0 || ram_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending_rsp=%0d pending_ram=%0d required 0 and 0",
                     rsp_q.size(), ram_q.size());
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
